// File: rtl/sirv_tl_pkg.sv
// ---------------------------------------------------------------------------
// sirv_tl_pkg
// Shared definitions for the QSPI flash TileLink-UL port.
//   - TileLink A/D opcode constants used by the port and its test bench.
//   - FSM state encoding of the port (IDLE, REQ, WAIT, RESP).
//   - flash_access_err(): decode of an accepted A request into an access
//     error flag (wrong opcode, wrong size, flash disabled, out of window).
// ---------------------------------------------------------------------------
package sirv_tl_pkg;

  // A channel opcodes
  localparam logic [2:0] TL_PUTFULL = 3'd0;
  localparam logic [2:0] TL_PUTPART = 3'd1;
  localparam logic [2:0] TL_GET     = 3'd4;

  // D channel opcodes
  localparam logic [2:0] TL_ACK     = 3'd0;
  localparam logic [2:0] TL_ACKDATA = 3'd1;

  // Port FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } tl_state_e;

  // An access is only serviceable when it is a single-byte Get, the flash is
  // memory-mapped, and the offset from the window base lands inside the
  // flash byte-address space. The caller passes the offset already shifted
  // right by the flash address width, so any set bit means out of window.
  function automatic logic flash_access_err(
    input logic [2:0]  opcode,
    input logic [2:0]  size,
    input logic        flash_en,
    input logic [29:0] off_hi
  );
    return (opcode != TL_GET) || (size != 3'd0) || !flash_en || (off_hi != 30'd0);
  endfunction

endpackage

// File: rtl/sirv_qspi_flash_tlport_if.sv
// ---------------------------------------------------------------------------
// sirv_qspi_flash_tlport_if
// Bundles the three handshake channels around the flash TileLink port:
//   A channel : a_valid/a_ready, a_opcode, a_size, a_source, a_address,
//               a_mask, a_data                     (fragmenter -> port)
//   D channel : d_valid/d_ready, d_opcode, d_param, d_size, d_source,
//               d_sink, d_addr_lo, d_data, d_error  (port -> fragmenter)
//   Engine    : f_req_valid/f_req_ready, f_req_addr, f_req_cont (port -> engine)
//               f_resp_valid, f_resp_data, f_cont_break        (engine -> port)
// Modports:
//   slave  : view of the TileLink port itself
//   master : view of the surrounding system (fragmenter + read engine)
// ---------------------------------------------------------------------------
interface sirv_qspi_flash_tlport_if #(
  parameter int SRC_W  = 7,
  parameter int ADDR_W = 24
);

  // A channel
  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [29:0]       a_address;
  logic              a_mask;
  logic [7:0]        a_data;

  // D channel
  logic              d_ready;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_addr_lo;
  logic [7:0]        d_data;
  logic              d_error;

  // Flash read engine
  logic              f_req_valid;
  logic              f_req_ready;
  logic [ADDR_W-1:0] f_req_addr;
  logic              f_req_cont;
  logic              f_resp_valid;
  logic [7:0]        f_resp_data;
  logic              f_cont_break;

  modport slave (
    output a_ready,
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo,
           d_data, d_error,
    output f_req_valid, f_req_addr, f_req_cont,
    input  f_req_ready, f_resp_valid, f_resp_data, f_cont_break
  );

  modport master (
    input  a_ready,
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo,
           d_data, d_error,
    input  f_req_valid, f_req_addr, f_req_cont,
    output f_req_ready, f_resp_valid, f_resp_data, f_cont_break
  );

endinterface

// File: rtl/sirv_qspi_flash_tlport.sv
// ---------------------------------------------------------------------------
// sirv_qspi_flash_tlport
// TileLink-UL slave port sitting behind the QSPI fragmenter. Each accepted A
// request is a single byte; valid Gets become one read request to the QSPI
// flash read engine, everything else is answered directly with an error.
// Only one transaction is in flight at a time. The port remembers the byte
// address that follows the last completed read so it can tell the engine
// when a new request simply continues the previous burst (the engine can
// then keep CS asserted and stay in continuous-read mode).
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flash_en   : memory-mapped flash mode enabled
//   bus        : A/D TileLink channels and the engine request/response
//                channels (sirv_qspi_flash_tlport_if.slave)
// ---------------------------------------------------------------------------
module sirv_qspi_flash_tlport
  import sirv_tl_pkg::*;
#(
  parameter int          ADDR_W = 24,
  parameter logic [29:0] BASE   = 30'h2000_0000,
  parameter int          SRC_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flash_en,
  sirv_qspi_flash_tlport_if.slave bus
);

  tl_state_e         state_q, state_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [2:0]        size_q, size_d;
  logic [SRC_W-1:0]  source_q, source_d;
  logic              addr_lo_q, addr_lo_d;
  logic [7:0]        data_q, data_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_cont_q, req_cont_d;
  logic              cont_vld_q, cont_vld_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;

  logic              a_hs;
  logic [29:0]       off;
  logic [ADDR_W-1:0] off_lo;
  logic              acc_err;

  // Offset into the flash window; an address below BASE wraps to a huge
  // offset and is therefore rejected by the window check.
  assign off     = bus.a_address - BASE;
  assign off_lo  = off[ADDR_W-1:0];
  assign acc_err = flash_access_err(bus.a_opcode, bus.a_size, flash_en, off >> ADDR_W);
  assign a_hs    = bus.a_valid && (state_q == ST_IDLE);

  // Write data and mask have no effect on a read-only flash window.
  logic unused_ok;
  assign unused_ok = ^{bus.a_mask, bus.a_data};

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    size_d      = size_q;
    source_d    = source_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;
    error_d     = error_q;
    req_addr_d  = req_addr_q;
    req_cont_d  = req_cont_q;
    cont_vld_d  = cont_vld_q;
    next_addr_d = next_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (a_hs) begin
          size_d    = bus.a_size;
          source_d  = bus.a_source;
          addr_lo_d = bus.a_address[0];
          if (acc_err) begin
            state_d  = ST_RESP;
            error_d  = 1'b1;
            data_d   = 8'h00;
            opcode_d = (bus.a_opcode == TL_GET) ? TL_ACKDATA : TL_ACK;
          end else begin
            state_d    = ST_REQ;
            error_d    = 1'b0;
            req_addr_d = off_lo;
            // A break arriving together with the accept already kills the
            // burst, so it must not be advertised as a continuation.
            req_cont_d = cont_vld_q && !bus.f_cont_break && (off_lo == next_addr_q);
          end
        end
      end

      ST_REQ: begin
        if (bus.f_req_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.f_resp_valid) begin
          state_d     = ST_RESP;
          data_d      = bus.f_resp_data;
          opcode_d    = TL_ACKDATA;
          error_d     = 1'b0;
          next_addr_d = req_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          cont_vld_d  = 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.d_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Losing continuous mode overrides the set from a completing read.
    if (bus.f_cont_break || !flash_en || (a_hs && acc_err)) begin
      cont_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= 3'd0;
      size_q      <= 3'd0;
      source_q    <= '0;
      addr_lo_q   <= 1'b0;
      data_q      <= 8'h00;
      error_q     <= 1'b0;
      req_addr_q  <= '0;
      req_cont_q  <= 1'b0;
      cont_vld_q  <= 1'b0;
      next_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      size_q      <= size_d;
      source_q    <= source_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
      error_q     <= error_d;
      req_addr_q  <= req_addr_d;
      req_cont_q  <= req_cont_d;
      cont_vld_q  <= cont_vld_d;
      next_addr_q <= next_addr_d;
    end
  end

  // A channel
  assign bus.a_ready     = (state_q == ST_IDLE);

  // Engine request: address and continuation flag come from flops so they
  // stay stable while the engine stalls.
  assign bus.f_req_valid = (state_q == ST_REQ);
  assign bus.f_req_addr  = req_addr_q;
  assign bus.f_req_cont  = req_cont_q;

  // D channel
  assign bus.d_valid     = (state_q == ST_RESP);
  assign bus.d_opcode    = opcode_q;
  assign bus.d_param     = 2'b00;
  assign bus.d_size      = size_q;
  assign bus.d_source    = source_q;
  assign bus.d_sink      = 1'b0;
  assign bus.d_addr_lo   = addr_lo_q;
  assign bus.d_data      = data_q;
  assign bus.d_error     = error_q;

  // The engine must only answer an outstanding request; a stray response
  // is dropped by the FSM above.
  resp_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n) bus.f_resp_valid |-> (state_q == ST_WAIT)
  );

endmodule

// File: tb/tb_sirv_qspi_flash_tlport.sv
// ---------------------------------------------------------------------------
// tb_sirv_qspi_flash_tlport
// Drives single-byte TileLink requests into the flash port, plays the flash
// read engine, and checks the D responses and engine requests against
// expectations queued when each request is issued.
// ---------------------------------------------------------------------------
module tb_sirv_qspi_flash_tlport;
  import sirv_tl_pkg::*;

  localparam int          ADDR_W = 24;
  localparam int          SRC_W  = 7;
  localparam logic [29:0] BASE   = 30'h2000_0000;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic flash_en = 1'b0;

  always #5 clk = ~clk;

  sirv_qspi_flash_tlport_if #(.SRC_W(SRC_W), .ADDR_W(ADDR_W)) bus ();

  sirv_qspi_flash_tlport #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .SRC_W  (SRC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flash_en (flash_en),
    .bus      (bus)
  );

  typedef struct packed {
    logic [2:0]       opcode;
    logic [7:0]       data;
    logic [SRC_W-1:0] source;
    logic             addr_lo;
    logic             error;
    logic [2:0]       size;
  } rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cont;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];

  int n_cmp      = 0;
  int n_bad      = 0;
  int req_hs_cnt = 0;
  int rsp_hs_cnt = 0;

  // Reference state of the continuous-burst tracker
  logic              m_cont_vld  = 1'b0;
  logic [ADDR_W-1:0] m_next_addr = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash contents seen through the engine
  function automatic logic [7:0] flash_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction

  always @(posedge clk) begin
    if (bus.f_req_valid && bus.f_req_ready) req_hs_cnt <= req_hs_cnt + 1;
    if (bus.d_valid && bus.d_ready)         rsp_hs_cnt <= rsp_hs_cnt + 1;
  end

  task automatic pulse_break();
    @(negedge clk);
    bus.f_cont_break = 1'b1;
    @(negedge clk);
    bus.f_cont_break = 1'b0;
    m_cont_vld = 1'b0;
    $display("  break pulse");
  endtask

  task automatic run_txn(
    input logic [2:0]       op,
    input logic [2:0]       sz,
    input logic [SRC_W-1:0] src,
    input logic [29:0]      addr,
    input int               req_stall,
    input int               resp_dly,
    input int               d_stall,
    input bit               brk_with_resp,
    input bit               rst_in_wait
  );
    logic [29:0]       off;
    bit                err;
    rsp_t              exp_rsp;
    rsp_t              snap;
    req_t              exp_req;
    int                hs0;
    int                rs0;
    int                guard;
    logic [ADDR_W-1:0] seen_addr;
    logic              seen_cont;

    off = addr - BASE;
    err = (op != TL_GET) || (sz != 3'd0) || !flash_en || (off >= 30'h100_0000);

    exp_rsp.source  = src;
    exp_rsp.size    = sz;
    exp_rsp.addr_lo = addr[0];
    if (err) begin
      exp_rsp.opcode = (op == TL_GET) ? 3'd1 : 3'd0;
      exp_rsp.data   = 8'h00;
      exp_rsp.error  = 1'b1;
      m_cont_vld     = 1'b0;
    end else begin
      exp_req.addr   = off[ADDR_W-1:0];
      exp_req.cont   = m_cont_vld && (off[ADDR_W-1:0] == m_next_addr);
      req_q.push_back(exp_req);
      exp_rsp.opcode = 3'd1;
      exp_rsp.data   = flash_byte(off[ADDR_W-1:0]);
      exp_rsp.error  = 1'b0;
    end
    if (!rst_in_wait) rsp_q.push_back(exp_rsp);

    hs0 = req_hs_cnt;
    rs0 = rsp_hs_cnt;

    @(negedge clk);
    check_val("a_ready_idle", bus.a_ready, 1);
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_size    = sz;
    bus.a_source  = src;
    bus.a_address = addr;
    bus.a_mask    = 1'b1;
    bus.a_data    = 8'($urandom);
    @(posedge clk);
    #1 bus.a_valid = 1'b0;

    if (!err) begin
      @(negedge clk);
      check_val("req_valid_lat", bus.f_req_valid, 1);
      seen_addr = bus.f_req_addr;
      seen_cont = bus.f_req_cont;
      for (int i = 0; i < req_stall; i++) begin
        @(negedge clk);
        check_val("req_hold", {bus.f_req_valid, bus.f_req_addr, bus.f_req_cont, bus.a_ready},
                  {1'b1, seen_addr, seen_cont, 1'b0});
      end
      exp_req = req_q.pop_front();
      check_val("req_addr", seen_addr, exp_req.addr);
      check_val("req_cont", seen_cont, exp_req.cont);
      bus.f_req_ready = 1'b1;
      @(posedge clk);
      #1 bus.f_req_ready = 1'b0;
      check_val("req_handshake", req_hs_cnt - hs0, 1);
      if (req_hs_cnt == hs0) begin
        rsp_q.delete();
        return;
      end

      if (rst_in_wait) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst_d_valid", bus.d_valid, 0);
        check_val("rst_req_valid", bus.f_req_valid, 0);
        check_val("rst_idle", bus.a_ready, 1);
        @(negedge clk);
        rst_n       = 1'b1;
        m_cont_vld  = 1'b0;
        m_next_addr = '0;
        repeat (3) @(negedge clk);
        check_val("rst_no_rsp", {bus.d_valid, 32'(rsp_hs_cnt - rs0)}, 0);
        $display("  txn op=%0d addr=0x%08h reset during WAIT", op, addr);
        return;
      end

      for (int i = 0; i < resp_dly; i++) @(negedge clk);
      check_val("no_early_d", bus.d_valid, 0);
      bus.f_resp_valid = 1'b1;
      bus.f_resp_data  = flash_byte(seen_addr);
      bus.f_cont_break = brk_with_resp;
      @(posedge clk);
      #1;
      bus.f_resp_valid = 1'b0;
      bus.f_cont_break = 1'b0;
      m_next_addr = off[ADDR_W-1:0] + 24'd1;
      m_cont_vld  = !brk_with_resp;
    end

    @(negedge clk);
    check_val("d_valid_lat", bus.d_valid, 1);
    guard = 0;
    while (!bus.d_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.d_valid) begin
      check_val("d_valid_timeout", bus.d_valid, 1);
      rsp_q.delete();
      return;
    end
    if (err) check_val("no_flash_req", req_hs_cnt - hs0, 0);

    snap = {bus.d_opcode, bus.d_data, bus.d_source, bus.d_addr_lo, bus.d_error, bus.d_size};
    for (int i = 0; i < d_stall; i++) begin
      @(negedge clk);
      check_val("d_hold",
                {bus.d_valid, bus.a_ready, bus.d_opcode, bus.d_data, bus.d_source,
                 bus.d_addr_lo, bus.d_error, bus.d_size},
                {1'b1, 1'b0, snap});
    end

    exp_rsp = rsp_q.pop_front();
    check_val("d_opcode",  bus.d_opcode,  exp_rsp.opcode);
    check_val("d_data",    bus.d_data,    exp_rsp.data);
    check_val("d_source",  bus.d_source,  exp_rsp.source);
    check_val("d_addr_lo", bus.d_addr_lo, exp_rsp.addr_lo);
    check_val("d_error",   bus.d_error,   exp_rsp.error);
    check_val("d_size",    bus.d_size,    exp_rsp.size);
    check_val("d_param_sink", {bus.d_param, bus.d_sink}, 0);
    $display("  txn op=%0d size=%0d src=0x%02h addr=0x%08h -> d_op=%0d data=0x%02h err=%0d",
             op, sz, src, addr, bus.d_opcode, bus.d_data, bus.d_error);

    bus.d_ready = 1'b1;
    @(posedge clk);
    #1 bus.d_ready = 1'b0;
    @(negedge clk);
    check_val("one_rsp", rsp_hs_cnt - rs0, 1);
    check_val("d_valid_drop", bus.d_valid, 0);
  endtask

  initial begin
    bus.a_valid      = 1'b0;
    bus.a_opcode     = 3'd0;
    bus.a_size       = 3'd0;
    bus.a_source     = '0;
    bus.a_address    = '0;
    bus.a_mask       = 1'b0;
    bus.a_data       = 8'h00;
    bus.d_ready      = 1'b0;
    bus.f_req_ready  = 1'b0;
    bus.f_resp_valid = 1'b0;
    bus.f_resp_data  = 8'h00;
    bus.f_cont_break = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_valids", {bus.d_valid, bus.f_req_valid}, 0);
    check_val("rst_d_fields",
              {bus.d_opcode, bus.d_data, bus.d_error, bus.d_size, bus.d_source, bus.d_addr_lo}, 0);
    check_val("rst_req_fields", {bus.f_req_addr, bus.f_req_cont}, 0);
    check_val("rst_param_sink", {bus.d_param, bus.d_sink}, 0);
    rst_n    = 1'b1;
    flash_en = 1'b1;
    @(negedge clk);

    // Basic read, then sequential / non-sequential continuation
    run_txn(TL_GET, 3'd0, 7'h45, 30'h2000_0010, 0, 3, 0, 0, 0);
    run_txn(TL_GET, 3'd0, 7'h01, 30'h2000_0011, 0, 1, 0, 0, 0);
    run_txn(TL_GET, 3'd0, 7'h02, 30'h2000_0020, 0, 2, 0, 0, 0);
    // Same sequence with a burst break between requests
    run_txn(TL_GET, 3'd0, 7'h03, 30'h2000_0010, 0, 1, 0, 0, 0);
    pulse_break();
    run_txn(TL_GET, 3'd0, 7'h04, 30'h2000_0011, 0, 1, 0, 0, 0);
    // Break coincident with the engine response clears continuation
    run_txn(TL_GET, 3'd0, 7'h05, 30'h2000_0012, 0, 0, 0, 1, 0);
    run_txn(TL_GET, 3'd0, 7'h06, 30'h2000_0013, 0, 1, 0, 0, 0);

    // Error accesses
    run_txn(TL_PUTFULL, 3'd0, 7'h03, 30'h2000_0000, 0, 0, 0, 0, 0);
    run_txn(TL_GET,     3'd0, 7'h07, 30'h2000_0014, 0, 1, 0, 0, 0);
    run_txn(TL_GET,     3'd0, 7'h08, 30'h2100_0000, 0, 0, 0, 0, 0);
    run_txn(TL_GET,     3'd1, 7'h09, 30'h2000_0015, 0, 0, 0, 0, 0);
    run_txn(TL_PUTPART, 3'd0, 7'h0A, 30'h2000_0017, 0, 0, 2, 0, 0);
    run_txn(TL_GET,     3'd0, 7'h0B, 30'h1FFF_FFFF, 0, 0, 0, 0, 0);
    flash_en = 1'b0;
    run_txn(TL_GET,     3'd0, 7'h0C, 30'h2000_0016, 0, 0, 0, 0, 0);
    flash_en = 1'b1;

    // Backpressure on both the engine and the D channel
    run_txn(TL_GET, 3'd0, 7'h7F, 30'h2000_0100, 4, 2, 5, 0, 0);

    // Address wrap at the top of the flash
    run_txn(TL_GET, 3'd0, 7'h11, 30'h20FF_FFFF, 0, 1, 0, 0, 0);
    run_txn(TL_GET, 3'd0, 7'h12, 30'h2000_0000, 0, 1, 0, 0, 0);

    // Reset while waiting on the engine, then continuation must be gone
    run_txn(TL_GET, 3'd0, 7'h13, 30'h2000_0001, 0, 1, 0, 0, 1);
    run_txn(TL_GET, 3'd0, 7'h14, 30'h2000_0001, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
